bus_initiator: RTL
==================

// Module: bus_initiator
// PURPOSE
//  CPU-side master of the 4-bit multiplexed instruction bus. Runs the 8-phase frame
//  (A1 A2 A3 M1 M2 X1 X2 X3): drives the 12-bit fetch address, captures the 8-bit
//  opcode returned by ROM responders, and issues the SRC / WRR / RDR command phases.
//  Sits between the core's fetch/execute logic and the ROM/IO chips on the shared bus.
// PARAMETERS
//  RESET_PC  12'h000  address fetched in the first frame after reset
//  IO_GROUP  4'hE     opcode high nibble marking an I/O-group instruction
//  WRR_OP    4'h2     I/O low nibble: write data to selected chip's output port
//  RDR_OP    4'hA     I/O low nibble: read selected chip's input port
// PORTS
//  clock          in   1   single clock; all state on posedge
//  reset          in   1   synchronous, active-high
//  halt           in   1   1 = freeze phase counter and all registers
//  data_i         in   4   bus nibble from responders
//  data_o         out  4   bus nibble driven by this block
//  data_en        out  1   1 = data_o is valid and owns the bus
//  sync           out  1   1 during phase 7 (X3): marks frame boundary
//  cmd            out  1   command strobe, active-low; idle 1
//  pc_i           in   12  next fetch address; sampled at end of phase 7
//  opcode_o       out  8   last fetched opcode {M1,M2}
//  opcode_valid_o out  1   1-cycle pulse in phase 5 when opcode_o updates
//  x_src_i        in   1   request SRC this frame; sampled in phase 5
//  x_data_i       in   4   SRC chip id / WRR data; sampled in phase 5
//  rdr_data_o     out  4   nibble read by RDR
//  rdr_valid_o    out  1   1-cycle pulse in phase 7 when rdr_data_o updates
// BEHAVIOUR
//  - phase: 3-bit counter 0..7, +1 per clock when !halt, wraps 7->0. Reset -> 0.
//  - Reset: phase=0, pc_lat=RESET_PC, opcode_o=0, rdr_data_o=0, all pulses 0, x regs 0.
//    First post-reset cycle is phase 0 driving RESET_PC[3:0]. Reset mid-frame aborts it.
//  - halt: no register changes; outputs (combinational from regs) hold; pulses that
//    are high stay high until halt releases, then drop after one further clock.
//  - Phase 0/1/2: data_en=1, data_o = pc_lat[3:0] / [7:4] / [11:8].
//  - Phase 3: data_en=0; capture data_i into op_hi. Phase 4: data_en=0; capture
//    data_i into op_lo. cmd=0 in phase 4 iff op_hi==IO_GROUP (combinational on op_hi).
//  - Phase 5: opcode_o <= {op_hi,op_lo} registered -> opcode_valid_o=1 this cycle;
//    latch x_src_i and x_data_i. data_en=0.
//  - Phase 6 decode (priority order):
//     io && op_lo==WRR_OP : data_en=1, data_o=x_data_i latched, cmd=1
//     io && op_lo==RDR_OP : data_en=0, sample data_i into rdr_data_o at end of phase
//     !io && x_src       : data_en=1, data_o=x_data latched, cmd=0 (SRC)
//     otherwise          : data_en=0, cmd=1
//    x_src_i is ignored in I/O-group frames; other I/O low nibbles act as no-op.
//  - rdr_valid_o=1 during phase 7 only in RDR frames.
//  - Phase 7: sync=1, cmd=1, data_en=0; pc_lat <= pc_i at end of phase 7.
//  - cmd is 1 in every phase not listed above; cmd never low in phase 6 of an I/O frame.
//  - data_o=0 whenever data_en=0. Never drives during phases 3,4,5,7.
// STRUCTURE
//  - Shared header bus_defs.vh: phase encodings (PH_A1..PH_X3 = 0..7), IO_GROUP,
//    WRR_OP, RDR_OP defaults; also used by ROM responders.
//  - Sub-module bus_phase_counter (clock, reset, halt -> phase[2:0]) shared with responders.
//  - Rest is one module: frame registers, phase-6 decode, output muxing.
// TESTING (bench pairs block with ROM responder model, CHIP_ID=0)
//  - Reset, ROM[0x000]=0x5C -> phases 0-2 drive 0,0,0; opcode_o=0x5C, valid pulse phase 5.
//  - pc_i=0x0A7, ROM[0xA7]=0x31 -> next frame drives 7,A,0; opcode_o=0x31; cmd stays 1.
//  - x_src_i=1,x_data_i=0 on non-IO frame -> phase 6 data_o=0,data_en=1,cmd=0; then
//    opcode 0xE2 frame, x_data_i=0x9 -> cmd=0 phase 4, phase 6 drives 9; port reads 0x9.
//  - After SRC, opcode 0xEA, responder input=0x6 -> data_en=0 phase 6, rdr_data_o=6,
//    rdr_valid_o pulse in phase 7.
//  - halt=1 for 5 cycles in phase 3 -> phase, data_en, opcode_o frozen; frame resumes
//    with identical result. Reset asserted in phase 5 -> phase=0, fetch RESET_PC.
//  - x_src_i=1 during opcode 0xE2 frame -> SRC suppressed, WRR performed, cmd=1 phase 6.

Source files
------------

// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the 4-bit multiplexed instruction bus: phase encodings,
// I/O-group opcode defaults and the phase-6 command decode.
package bus_initiator_pkg;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam logic [11:0] RESET_PC_DEF = 12'h000;
    localparam logic [3:0]  IO_GROUP_DEF = 4'hE;
    localparam logic [3:0]  WRR_OP_DEF   = 4'h2;
    localparam logic [3:0]  RDR_OP_DEF   = 4'hA;

    typedef enum logic [1:0] {
        XNone,
        XWrr,
        XRdr,
        XSrc
    } x_action_e;

    // I/O-group frames ignore the SRC request entirely.
    function automatic x_action_e decode_x(input logic [3:0] op_hi,
                                           input logic [3:0] op_lo,
                                           input logic       x_src,
                                           input logic [3:0] io_group,
                                           input logic [3:0] wrr_op,
                                           input logic [3:0] rdr_op);
        if (op_hi == io_group) begin
            if (op_lo == wrr_op) return XWrr;
            if (op_lo == rdr_op) return XRdr;
            return XNone;
        end
        return x_src ? XSrc : XNone;
    endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Shared 4-bit multiplexed bus: nibble in each direction, drive enable, frame sync
// and active-low command strobe.
interface bus_initiator_if;

    logic [3:0] data_i;
    logic [3:0] data_o;
    logic       data_en;
    logic       sync;
    logic       cmd;

    modport master (
        input  data_i,
        output data_o,
        output data_en,
        output sync,
        output cmd
    );

    modport slave (
        output data_i,
        input  data_o,
        input  data_en,
        input  sync,
        input  cmd
    );

endinterface

// File: rtl/bus_phase_counter.sv
// Eight-phase frame counter (A1..X3), frozen while halt is high.
module bus_phase_counter
    import bus_initiator_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       halt,
    output logic [2:0] phase
);

    logic [2:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (!halt) begin
            phase_d = (phase_q == PH_X3) ? PH_A1 : phase_q + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= PH_A1;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/bus_initiator.sv
// CPU-side bus master: sends the fetch address, collects the opcode from ROM and
// issues the SRC / WRR / RDR command phases of each eight-phase frame.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter logic [11:0] RESET_PC = RESET_PC_DEF,
    parameter logic [3:0]  IO_GROUP = IO_GROUP_DEF,
    parameter logic [3:0]  WRR_OP   = WRR_OP_DEF,
    parameter logic [3:0]  RDR_OP   = RDR_OP_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   halt,
    bus_initiator_if.master        bus,
    input  logic [11:0]            pc_i,
    output logic [7:0]             opcode_o,
    output logic                   opcode_valid_o,
    input  logic                   x_src_i,
    input  logic [3:0]             x_data_i,
    output logic [3:0]             rdr_data_o,
    output logic                   rdr_valid_o
);

    logic [2:0]  phase;
    logic [11:0] pc_lat_q, pc_lat_d;
    logic [3:0]  op_hi_q, op_hi_d;
    logic [3:0]  op_lo_q, op_lo_d;
    logic [7:0]  opcode_q, opcode_d;
    logic        opcode_valid_q, opcode_valid_d;
    logic        x_src_q, x_src_d;
    logic [3:0]  x_data_q, x_data_d;
    logic [3:0]  rdr_data_q, rdr_data_d;
    logic        rdr_valid_q, rdr_valid_d;
    x_action_e   x_act;

    bus_phase_counter u_phase (
        .clock (clock),
        .reset (reset),
        .halt  (halt),
        .phase (phase)
    );

    assign x_act = decode_x(op_hi_q, op_lo_q, x_src_q, IO_GROUP, WRR_OP, RDR_OP);

    always_comb begin
        pc_lat_d       = pc_lat_q;
        op_hi_d        = op_hi_q;
        op_lo_d        = op_lo_q;
        opcode_d       = opcode_q;
        opcode_valid_d = opcode_valid_q;
        x_src_d        = x_src_q;
        x_data_d       = x_data_q;
        rdr_data_d     = rdr_data_q;
        rdr_valid_d    = rdr_valid_q;
        if (!halt) begin
            opcode_valid_d = 1'b0;
            rdr_valid_d    = 1'b0;
            case (phase)
                PH_M1: op_hi_d = bus.data_i;
                // Opcode and its pulse load together so both are visible throughout X1.
                PH_M2: begin
                    op_lo_d        = bus.data_i;
                    opcode_d       = {op_hi_q, bus.data_i};
                    opcode_valid_d = 1'b1;
                end
                PH_X1: begin
                    x_src_d  = x_src_i;
                    x_data_d = x_data_i;
                end
                PH_X2: begin
                    if (x_act == XRdr) begin
                        rdr_data_d  = bus.data_i;
                        rdr_valid_d = 1'b1;
                    end
                end
                PH_X3: pc_lat_d = pc_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_lat_q       <= RESET_PC;
            op_hi_q        <= 4'h0;
            op_lo_q        <= 4'h0;
            opcode_q       <= 8'h00;
            opcode_valid_q <= 1'b0;
            x_src_q        <= 1'b0;
            x_data_q       <= 4'h0;
            rdr_data_q     <= 4'h0;
            rdr_valid_q    <= 1'b0;
        end else begin
            pc_lat_q       <= pc_lat_d;
            op_hi_q        <= op_hi_d;
            op_lo_q        <= op_lo_d;
            opcode_q       <= opcode_d;
            opcode_valid_q <= opcode_valid_d;
            x_src_q        <= x_src_d;
            x_data_q       <= x_data_d;
            rdr_data_q     <= rdr_data_d;
            rdr_valid_q    <= rdr_valid_d;
        end
    end

    always_comb begin
        bus.data_o  = 4'h0;
        bus.data_en = 1'b0;
        bus.sync    = 1'b0;
        bus.cmd     = 1'b1;
        case (phase)
            PH_A1: begin
                bus.data_en = 1'b1;
                bus.data_o  = pc_lat_q[3:0];
            end
            PH_A2: begin
                bus.data_en = 1'b1;
                bus.data_o  = pc_lat_q[7:4];
            end
            PH_A3: begin
                bus.data_en = 1'b1;
                bus.data_o  = pc_lat_q[11:8];
            end
            PH_M2: bus.cmd = (op_hi_q != IO_GROUP);
            PH_X2: begin
                case (x_act)
                    XWrr: begin
                        bus.data_en = 1'b1;
                        bus.data_o  = x_data_q;
                    end
                    XSrc: begin
                        bus.data_en = 1'b1;
                        bus.data_o  = x_data_q;
                        bus.cmd     = 1'b0;
                    end
                    default: ;
                endcase
            end
            PH_X3: bus.sync = 1'b1;
            default: ;
        endcase
    end

    assign opcode_o       = opcode_q;
    assign opcode_valid_o = opcode_valid_q;
    assign rdr_data_o     = rdr_data_q;
    assign rdr_valid_o    = rdr_valid_q;

endmodule
